imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width in bits.
REQ-002 Parameter DATA_W, default 32, instruction word width in bits.
REQ-003 Parameter READ_LAT, default 2, cycles from a read address being presented to valid mem_q.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; port list follows.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin load; sampled only in IDLE.
REQ-008 word_count  input  ADDR_W  number of words to load; latched on accepted start.
REQ-009 in_valid  input  1  source presents a word.
REQ-010 in_data  input  DATA_W  instruction word.
REQ-011 in_ready  output  1  loader accepts a word this cycle.
REQ-012 mem_address  output  ADDR_W  instruction-memory address.
REQ-013 mem_data  output  DATA_W  instruction-memory write data.
REQ-014 mem_wren  output  1  instruction-memory write enable.
REQ-015 mem_q  input  DATA_W  instruction-memory read data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at end of load.
REQ-018 error  output  1  readback checksum mismatch; sticky.

Function
REQ-019 States SHALL be IDLE, LOAD, VERIFY, DONE.
REQ-020 IDLE: in_ready=0, mem_wren=0; start=1 latches word_count, clears index, checksums and error.
- Next state is LOAD, or DONE when word_count=0.
REQ-021 LOAD: in_ready=1; a word is accepted only when in_valid and in_ready are both 1.
REQ-022 Accepted word k SHALL appear on mem_address=k, mem_data=word, mem_wren=1 exactly one cycle after the handshake (registered outputs).
- mem_wren=0 in all other cycles.
REQ-023 Each accepted word SHALL be XORed into the write checksum (DATA_W bits).
REQ-024 Acceptance of word count-1 SHALL drop in_ready the next cycle and enter VERIFY.
- The write of that word still completes.
REQ-025 VERIFY: read addresses 0..count-1 are issued one per cycle with mem_wren=0.
- Data is captured READ_LAT cycles after each address, tracked by a READ_LAT-deep valid shift register.
- Captured data is XORed into the read checksum.
REQ-026 After the last captured return, error=(write checksum != read checksum); next state is DONE.
REQ-027 DONE lasts one cycle: done=1, then IDLE.
REQ-028 start while busy SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-029 in_valid low in LOAD SHALL stall without timeout; index and checksum hold.
REQ-030 Index arithmetic is ADDR_W unsigned; maximum load is 2^ADDR_W-1 words, so no wrap occurs.
REQ-031 word_count=0: no memory access; done pulses 1 cycle after start; error=0.

Reset
REQ-032 rst=0 SHALL immediately force IDLE and set in_ready, mem_wren, busy, done, error, mem_address, mem_data, index and checksums to 0.
REQ-033 Reset mid-LOAD or mid-VERIFY SHALL abort; partially written memory is not restored; no done pulse.

Structure
REQ-034 A shared package SHALL hold the state encoding and the ADDR_W/DATA_W defaults, also used by the control unit.
REQ-035 One sub-module, imem_read_tracker, SHALL implement the READ_LAT valid shift register and read-checksum accumulation.

Verification
REQ-036 Load words 0x00000013, 0x00100093, 0x00208113 with in_valid always high.
- Required: writes at addr 0,1,2 on consecutive cycles; 3 reads; done pulse; error=0.
REQ-037 word_count=0, start=1 -> done=1 next cycle, mem_wren never asserted, error=0.
REQ-038 Load 4 words with in_valid deasserted 3 cycles between words -> each write is 1 cycle after its handshake; addresses 0..3; error=0.
REQ-039 Memory model corrupts addr 1 readback (XOR 0x1) -> error=1 with done, held until next accepted start.
REQ-040 Reset asserted after 2 of 5 words -> all outputs 0 asynchronously, state IDLE; new start with count 1 completes normally.
REQ-041 start pulsed during VERIFY -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default widths,
// read latency and the control-FSM state encoding.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W   = 8;
  localparam int IMEM_DATA_W   = 32;
  localparam int IMEM_READ_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } imem_state_e;

endpackage

// File: rtl/imem_read_tracker.sv
// Follows outstanding instruction-memory reads through a READ_LAT-deep valid
// shift register and folds each returned word into the read checksum.
module imem_read_tracker
  import imem_loader_pkg::*;
#(
  parameter int DATA_W   = IMEM_DATA_W,
  parameter int READ_LAT = IMEM_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] rd_csum,
  output logic              idle
);

  // Bit i set: a read address was on the bus i+1 cycles ago.
  logic [READ_LAT-1:0] vld_sr;

  // Advance the valid pipeline; the oldest stage marks mem_q as valid now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr  <= '0;
      rd_csum <= '0;
    end else if (clear) begin
      vld_sr  <= '0;
      rd_csum <= '0;
    end else begin
      vld_sr[0] <= rd_issue;
      for (int i = 1; i < READ_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (vld_sr[READ_LAT-1]) rd_csum <= rd_csum ^ mem_q;
    end
  end

  assign idle = ~|vld_sr;

endmodule

// File: rtl/imem_loader.sv
// Streams words from a valid/ready source into instruction memory, then reads
// the memory back and compares XOR checksums of written and returned data.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready are
// both high; in_ready depends only on state, never on in_valid, and the source
// holds in_data stable while in_valid is high and in_ready is low.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = IMEM_ADDR_W,
  parameter int DATA_W   = IMEM_DATA_W,
  parameter int READ_LAT = IMEM_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              error,
  output imem_state_e       state_dbg
);

  imem_state_e       state, state_nxt;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] idx;        // write index in LOAD, read index in VERIFY
  logic [DATA_W-1:0] wr_csum;
  logic [DATA_W-1:0] rd_csum;
  logic              rd_present; // mem_address currently carries a read
  logic              all_issued;
  logic              trk_idle;
  logic              accept;
  logic              wr_hs;
  logic              last_idx;
  logic              verify_end;

  assign accept     = start && (state == ST_IDLE);
  assign wr_hs      = in_valid && (state == ST_LOAD);
  assign last_idx   = (idx == count - 1'b1);
  assign verify_end = (state == ST_VERIFY) && all_issued && !rd_present && trk_idle;
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (word_count == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_idx) state_nxt = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (verify_end) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch the job, register memory writes/reads, keep checksums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      idx         <= '0;
      wr_csum     <= '0;
      error       <= 1'b0;
      all_issued  <= 1'b0;
      rd_present  <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      mem_wren   <= 1'b0;
      rd_present <= 1'b0;
      if (accept) begin
        count      <= word_count;
        idx        <= '0;
        wr_csum    <= '0;
        error      <= 1'b0;
        all_issued <= 1'b0;
      end
      if (wr_hs) begin
        mem_address <= idx;
        mem_data    <= in_data;
        mem_wren    <= 1'b1;
        wr_csum     <= wr_csum ^ in_data;
        // The index restarts at zero so VERIFY can reuse it for reads.
        idx         <= last_idx ? '0 : idx + 1'b1;
      end
      if ((state == ST_VERIFY) && !all_issued) begin
        mem_address <= idx;
        rd_present  <= 1'b1;
        idx         <= idx + 1'b1;
        if (last_idx) all_issued <= 1'b1;
      end
      if (verify_end) error <= (wr_csum != rd_csum);
    end
  end

  imem_read_tracker #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_read_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .rd_issue (rd_present),
    .mem_q    (mem_q),
    .rd_csum  (rd_csum),
    .idle     (trk_idle)
  );

endmodule
